// File: rtl/colparity_pkg.sv
// Shared definitions for the column-parity slice: frame geometry defaults,
// counter widths and the sequencer state encoding.
package colparity_pkg;

    localparam int COLP_LINES  = 64;
    localparam int COLP_ROUNDS = 24;
    localparam int COLP_LW     = 7;
    localparam int COLP_TW     = 5;

    localparam int COLP_STALL_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LD_CURR = 3'd1,
        ST_LD_PREV = 3'd2,
        ST_CALC    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
    } colp_state_t;

    typedef struct packed {
        logic ld_curr_fr;
        logic ld_prev_fr;
        logic cap_curr;
        logic cp_en;
        logic wr_en;
        logic busy;
        logic done;
    } colp_strobes_t;

endpackage

// File: rtl/colparity_line_cnt.sv
// Line/turn counter pair for the column-parity sequencer: line runs 1..LINES,
// turn runs 0..ROUNDS-1, both wrap explicitly and expose last-flags.
module colparity_line_cnt
    import colparity_pkg::*;
#(
    parameter int LINES  = COLP_LINES,
    parameter int ROUNDS = COLP_ROUNDS,
    parameter int LW     = COLP_LW,
    parameter int TW     = COLP_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [LW-1:0] line_number,
    output logic [TW-1:0] turn,
    output logic          last_line,
    output logic          last_round
);

    assign last_line  = (line_number == LW'(LINES));
    assign last_round = (turn == TW'(ROUNDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_number <= LW'(1);
            turn        <= '0;
        end else if (clear) begin
            line_number <= LW'(1);
            turn        <= '0;
        end else if (advance) begin
            if (last_line) begin
                // The final line of the final round wraps both, so nothing
                // ever exceeds LINES / ROUNDS-1.
                line_number <= LW'(1);
                turn        <= last_round ? '0 : turn + TW'(1);
            end else begin
                line_number <= line_number + LW'(1);
            end
        end
    end

endmodule

// File: rtl/colparity_seq_ctrl.sv
// Column-parity sequencer: per line issues current load, previous load,
// parity compute and a handshaked write. Optional stall counter: COLP_STALL_CNT_EN.
module colparity_seq_ctrl
    import colparity_pkg::*;
#(
    parameter int LINES  = COLP_LINES,
    parameter int ROUNDS = COLP_ROUNDS,
    parameter int LW     = COLP_LW,
    parameter int TW     = COLP_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_ack,
    output logic          ld_curr_fr,
    output logic          ld_prev_fr,
    output logic [LW-1:0] line_number,
    output logic [TW-1:0] turn,
    output logic          cap_curr,
    output logic          cp_en,
    output logic          wr_en,
    output logic          busy,
    output logic          done
`ifdef COLP_STALL_CNT_EN
    ,
    output logic [COLP_STALL_W-1:0] stall_cnt
`endif
);

    colp_state_t   state, state_nxt;
    colp_strobes_t strb;
    logic          last_line, last_round;
    logic          line_adv;

    assign line_adv = (state == ST_WRITE) && wr_ack;

    colparity_line_cnt #(
        .LINES  (LINES),
        .ROUNDS (ROUNDS),
        .LW     (LW),
        .TW     (TW)
    ) u_line_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear       (state == ST_IDLE),
        .advance     (line_adv),
        .line_number (line_number),
        .turn        (turn),
        .last_line   (last_line),
        .last_round  (last_round)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: default assignment first, so no path through the case leaves the
    // output unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_LD_CURR;
            ST_LD_CURR: state_nxt = ST_LD_PREV;
            ST_LD_PREV: state_nxt = ST_CALC;
            ST_CALC:    state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (wr_ack)
                    state_nxt = (last_line && last_round) ? ST_DONE : ST_LD_CURR;
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Moore strobes: decoded from state alone, so at most one load/compute/write is active.
    always_comb begin
        strb = '0;
        unique case (state)
            ST_IDLE:    ;
            ST_LD_CURR: strb.ld_curr_fr = 1'b1;
            ST_LD_PREV: begin
                strb.ld_prev_fr = 1'b1;
                strb.cap_curr   = 1'b1;
            end
            ST_CALC:    strb.cp_en = 1'b1;
            ST_WRITE:   strb.wr_en = 1'b1;
            ST_DONE:    strb.done  = 1'b1;
            default:    ;
        endcase
        strb.busy = (state != ST_IDLE);
    end

    assign ld_curr_fr = strb.ld_curr_fr;
    assign ld_prev_fr = strb.ld_prev_fr;
    assign cap_curr   = strb.cap_curr;
    assign cp_en      = strb.cp_en;
    assign wr_en      = strb.wr_en;
    assign busy       = strb.busy;
    assign done       = strb.done;

`ifdef COLP_STALL_CNT_EN
    // Counts writer back-pressure for the current job; kept after DONE for readout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == ST_WRITE && !wr_ack && stall_cnt != {COLP_STALL_W{1'b1}}) begin
            stall_cnt <= stall_cnt + COLP_STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_colparity_seq_ctrl.sv
// Self-checking bench for colparity_seq_ctrl: a small instance (4 lines, 2 rounds)
// and a default instance, both tracked against a job-position model.
module tb_colparity_seq_ctrl;

    localparam int LW = 7;
    localparam int TW = 5;
    localparam int VW = 7 + LW + TW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // index 0: small instance, index 1: default instance
    logic          start_v [2];
    logic          ack_v   [2];
    logic          ldc [2], ldp [2], cap [2], cpe [2], wre [2], bsy [2], dne [2];
    logic [LW-1:0] line [2];
    logic [TW-1:0] trn  [2];
`ifdef COLP_STALL_CNT_EN
    logic [15:0]   stl [2];
`endif

    colparity_seq_ctrl #(.LINES(4), .ROUNDS(2), .LW(LW), .TW(TW)) dut_s (
        .clk(clk), .rst(rst), .start(start_v[0]), .wr_ack(ack_v[0]),
        .ld_curr_fr(ldc[0]), .ld_prev_fr(ldp[0]), .line_number(line[0]), .turn(trn[0]),
        .cap_curr(cap[0]), .cp_en(cpe[0]), .wr_en(wre[0]), .busy(bsy[0]), .done(dne[0])
`ifdef COLP_STALL_CNT_EN
        , .stall_cnt(stl[0])
`endif
    );

    colparity_seq_ctrl dut_d (
        .clk(clk), .rst(rst), .start(start_v[1]), .wr_ack(ack_v[1]),
        .ld_curr_fr(ldc[1]), .ld_prev_fr(ldp[1]), .line_number(line[1]), .turn(trn[1]),
        .cap_curr(cap[1]), .cp_en(cpe[1]), .wr_en(wre[1]), .busy(bsy[1]), .done(dne[1])
`ifdef COLP_STALL_CNT_EN
        , .stall_cnt(stl[1])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a job is a flat position count; each line is 4 steps, step 3 waits for ack.
    int lines_of  [2] = '{4, 64};
    int rounds_of [2] = '{2, 24};
    bit m_act  [2];
    bit m_done [2];
    int m_pos  [2];
    int m_stall[2];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_act[i] = 0; m_done[i] = 0; m_pos[i] = 0; m_stall[i] = 0;
            end else if (m_done[i]) begin
                m_done[i] = 0;
            end else if (!m_act[i]) begin
                if (start_v[i]) begin
                    m_act[i] = 1; m_pos[i] = 0; m_stall[i] = 0;
                end
            end else if (m_pos[i] % 4 == 3 && !ack_v[i]) begin
                if (m_stall[i] < 65535) m_stall[i]++;
            end else if (m_pos[i] == lines_of[i] * rounds_of[i] * 4 - 1) begin
                m_act[i] = 0; m_done[i] = 1;
            end else begin
                m_pos[i]++;
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec(input int i);
        int ph, ln, tn;
        ph = m_pos[i] % 4;
        ln = m_act[i] ? (m_pos[i] / 4) % lines_of[i] + 1 : 1;
        tn = m_act[i] ? (m_pos[i] / 4) / lines_of[i] : 0;
        return {m_act[i] | m_done[i], m_done[i],
                m_act[i] && ph == 0, m_act[i] && ph == 1, m_act[i] && ph == 1,
                m_act[i] && ph == 2, m_act[i] && ph == 3,
                LW'(ln), TW'(tn)};
    endfunction

    function automatic logic [VW-1:0] dut_vec(input int i);
        return {bsy[i], dne[i], ldc[i], ldp[i], cap[i], cpe[i], wre[i], line[i], trn[i]};
    endfunction

    function automatic logic [4:0] strobes(input int i);
        return {ldc[i], ldp[i], cap[i], cpe[i], wre[i]};
    endfunction

    always @(negedge clk) begin
        check("small_outputs", 32'(dut_vec(0)), 32'(exp_vec(0)));
        check("dflt_outputs",  32'(dut_vec(1)), 32'(exp_vec(1)));
`ifdef COLP_STALL_CNT_EN
        check("small_stall_cnt", 32'(stl[0]), 32'(m_stall[0]));
        check("dflt_stall_cnt",  32'(stl[1]), 32'(m_stall[1]));
`endif
    end

    task automatic wait_done(input int i, input string name);
        bit seen = 0;
        for (int c = 0; c < 10000 && !seen; c++) begin
            @(negedge clk);
            seen = dne[i];
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic start_job(input int i);
        @(negedge clk); start_v[i] = 1'b1;
        @(negedge clk); start_v[i] = 1'b0;
    endtask

    initial begin
        int cyc;
        int wr_cnt;
        bit seen;
        logic [4:0] st_hist [4];

        start_v = '{1'b0, 1'b0};
        ack_v   = '{1'b1, 1'b1};
        repeat (3) @(negedge clk);
        check("reset_busy_small", 32'(bsy[0]), 32'd0);
        check("reset_line_small", 32'(line[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // No-stall job on the small instance: done 33 cycles after start.
        start_v[0] = 1'b1;
        cyc = 0; seen = 0;
        while (cyc < 100 && !seen) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            cyc++;
            if (cyc <= 4) st_hist[cyc-1] = strobes(0);
            seen = dne[0];
        end
        check("t2_done_latency", 32'(cyc), 32'd33);
        check("t2_strobe_c1", 32'(st_hist[0]), 32'b10000);
        check("t2_strobe_c2", 32'(st_hist[1]), 32'b01100);
        check("t2_strobe_c3", 32'(st_hist[2]), 32'b00010);
        check("t2_strobe_c4", 32'(st_hist[3]), 32'b00001);
        @(negedge clk);
        check("t2_idle_after_done", 32'(bsy[0]), 32'd0);

        // Stall at line 2 with a start pulse during the stall.
        start_job(0);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (cpe[0] && line[0] == 2 && trn[0] == 0) begin
                ack_v[0] = 1'b0; seen = 1;
            end else @(negedge clk);
        end
        check("t3_reach_line2", 32'(seen), 32'd1);
        wr_cnt = 0;
        for (int c = 0; c < 12 && wr_cnt < 6; c++) begin
            @(negedge clk);
            if (wre[0]) wr_cnt++;
            start_v[0] = (wr_cnt == 3);
            if (wr_cnt == 6) ack_v[0] = 1'b1;
        end
        check("t3_wr_cycles", 32'(wr_cnt), 32'd6);
        check("t3_line_held", 32'(line[0]), 32'd2);
        check("t6_turn_held", 32'(trn[0]), 32'd0);
`ifdef COLP_STALL_CNT_EN
        check("t3_stall_cnt", 32'(stl[0]), 32'd5);
`endif
        @(negedge clk);
        check("t3_next_line", 32'(line[0]), 32'd3);
        check("t3_next_ldcurr", 32'(ldc[0]), 32'd1);
        wait_done(0, "t3_done_seen");

        // New job after DONE restarts from line 1, turn 0.
        start_job(0);
        check("t6_restart_ldcurr", 32'(ldc[0]), 32'd1);
        check("t6_restart_line", 32'(line[0]), 32'd1);
        check("t6_restart_turn", 32'(trn[0]), 32'd0);
        wait_done(0, "t6_done_seen");

        // Reset mid-WRITE at line 17, turn 3 on the default instance.
        start_job(1);
        seen = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (cpe[1] && line[1] == 17 && trn[1] == 3) ack_v[1] = 1'b0;
            seen = wre[1] && line[1] == 17 && trn[1] == 3;
        end
        check("t1_reach_l17_t3", 32'(seen), 32'd1);
        @(negedge clk);
        check("t1_stalled_line", 32'(line[1]), 32'd17);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t1_rst_strobes", 32'(strobes(1)), 32'd0);
        check("t1_rst_line", 32'(line[1]), 32'd1);
        check("t1_rst_turn", 32'(trn[1]), 32'd0);
        check("t1_rst_busy", 32'(bsy[1]), 32'd0);
        rst = 1'b1; ack_v[1] = 1'b1;
        @(negedge clk);

        // Full default job: line/turn wrap and last-line DONE.
        start_job(1);
        check("t1_newjob_line", 32'(line[1]), 32'd1);
        seen = 0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            seen = wre[1] && line[1] == 64 && trn[1] == 0;
        end
        check("t4_reach_l64_t0", 32'(seen), 32'd1);
        @(negedge clk);
        check("t4_wrap_line", 32'(line[1]), 32'd1);
        check("t4_wrap_turn", 32'(trn[1]), 32'd1);
        check("t4_wrap_ldcurr", 32'(ldc[1]), 32'd1);
        seen = 0;
        for (int c = 0; c < 7000 && !seen; c++) begin
            @(negedge clk);
            seen = wre[1] && line[1] == 64 && trn[1] == 23;
        end
        check("t5_reach_l64_t23", 32'(seen), 32'd1);
        @(negedge clk);
        check("t5_done_high", 32'(dne[1]), 32'd1);
        @(negedge clk);
        check("t5_done_low", 32'(dne[1]), 32'd0);
        check("t5_busy_low", 32'(bsy[1]), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
